seg_to_bin: RTL and testbench

SEG_TO_BIN -- requirements
Module: seg_to_bin

---
 rtl/seg_to_bin.sv | 144 ++++++++++++++
 tb/tb_seg_to_bin.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_to_bin.sv
// Converts a three-digit seven-segment display word into a 10-bit binary value
// using a serial reverse double-dabble (one iteration per clock).
module seg_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] seg_100,
    input  logic [6:0] seg_10,
    input  logic [6:0] seg_1,
    output logic       out_valid,
    output logic [9:0] out_binary,
    output logic       out_err,
    output logic       busy
);

    // state  | meaning
    // IDLE   | waiting for in_valid, segment codes captured on accept
    // DECODE | segment codes -> BCD digits, illegal code short-cuts to OUT
    // CONV   | ten shift-right / subtract-3 iterations on the work register
    // OUT    | registers the result strobe, then back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        CONV   = 2'd2,
        OUT    = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [20:0] codes_q,      codes_d;
    logic [21:0] work_q,       work_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic        err_q,        err_d;
    logic        out_valid_q,  out_valid_d;
    logic [9:0]  out_binary_q, out_binary_d;
    logic        out_err_q,    out_err_d;

    logic [4:0]  dec_h, dec_t, dec_u;
    logic [21:0] shifted;
    logic [21:0] iter_next;

    // Returns {illegal, digit}; a..g map to bits 6..0, active-high.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E:   r = 5'd0;
            7'h30:   r = 5'd1;
            7'h6D:   r = 5'd2;
            7'h79:   r = 5'd3;
            7'h33:   r = 5'd4;
            7'h5B:   r = 5'd5;
            7'h5F:   r = 5'd6;
            7'h70:   r = 5'd7;
            7'h7F:   r = 5'd8;
            7'h7B:   r = 5'd9;
            default: r = 5'b1_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_h = seg_decode(codes_q[20:14]);
        dec_t = seg_decode(codes_q[13:7]);
        dec_u = seg_decode(codes_q[6:0]);
    end

    // Fields are only corrected when >= 8, so the subtraction can never wrap.
    always_comb begin
        shifted   = work_q >> 1;
        iter_next = shifted;
        if (shifted[21:18] >= 4'd8) iter_next[21:18] = shifted[21:18] - 4'd3;
        if (shifted[17:14] >= 4'd8) iter_next[17:14] = shifted[17:14] - 4'd3;
        if (shifted[13:10] >= 4'd8) iter_next[13:10] = shifted[13:10] - 4'd3;
    end

    always_comb begin
        state_d      = state_q;
        codes_d      = codes_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_valid_d  = 1'b0;
        out_binary_d = out_binary_q;
        out_err_d    = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    codes_d = {seg_100, seg_10, seg_1};
                    err_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_h[4] || dec_t[4] || dec_u[4]) begin
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    work_d  = {dec_h[3:0], dec_t[3:0], dec_u[3:0], 10'b0};
                    cnt_d   = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                work_d = iter_next;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = OUT;
            end
            OUT: begin
                out_valid_d  = 1'b1;
                out_binary_d = err_q ? 10'd0 : work_q[9:0];
                out_err_d    = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            codes_q      <= '0;
            work_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_binary_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            codes_q      <= codes_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_binary_q <= out_binary_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_binary = out_binary_q;
    assign out_err    = out_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seg_to_bin.sv
// Directed bench for seg_to_bin: expected results are queued when a request is
// driven and checked (value, error flag, arrival edge) when out_valid pulses.
module tb_seg_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] seg_100, seg_10, seg_1;
    logic       out_valid;
    logic [9:0] out_binary;
    logic       out_err;
    logic       busy;

    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    seg_to_bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .seg_100   (seg_100),
        .seg_10    (seg_10),
        .seg_1     (seg_1),
        .out_valid (out_valid),
        .out_binary(out_binary),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one in_valid strobe; queue the expected result only when the
    // request should be accepted.
    task automatic drive(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u,
                         input logic [9:0] bin, input logic err, input logic accept);
        exp_t e;
        @(negedge clk);
        seg_100  = h;
        seg_10   = t;
        seg_1    = u;
        in_valid = 1'b1;
        if (accept) begin
            e.bin = bin;
            e.err = err;
            e.due = cyc + 1 + (err ? 2 : 12);
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, (sb.size() == 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_binary", {22'd0, out_binary}, {22'd0, e.bin});
                chk("out_err", {31'd0, out_err}, {31'd0, e.err});
                chk("latency_edge", cyc, e.due);
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b1;
        seg_100  = 7'h7B;
        seg_10   = 7'h7B;
        seg_1    = 7'h7B;
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_binary", {22'd0, out_binary}, 32'd0);
        chk("rst_out_err",    {31'd0, out_err}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        drive(7'h7B, 7'h7B, 7'h7B, 10'd999, 1'b0, 1'b1);
        chk("busy_after_capture", {31'd0, busy}, 32'd1);
        drain("v999");

        drive(7'h30, 7'h7E, 7'h7E, 10'd100, 1'b0, 1'b1);
        drain("v100");
        drive(7'h7E, 7'h7E, 7'h7E, 10'd0, 1'b0, 1'b1);
        drain("v000");

        drive(7'h5F, 7'h00, 7'h33, 10'd0, 1'b1, 1'b1);
        drain("illegal");
        chk("err_hold", {31'd0, out_err}, 32'd1);

        // 523 with stray strobes at cycles 3 and 8 of the conversion
        drive(7'h5B, 7'h6D, 7'h79, 10'd523, 1'b0, 1'b1);
        drive(7'h7F, 7'h7F, 7'h7F, 10'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        drive(7'h30, 7'h00, 7'h30, 10'd0, 1'b0, 1'b0);
        chk("busy_mid_conv", {31'd0, busy}, 32'd1);
        drain("v523");
        chk("binary_hold", {22'd0, out_binary}, 32'd523);

        // back-to-back: next request in the out_valid cycle
        drive(7'h33, 7'h5F, 7'h70, 10'd467, 1'b0, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wait_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_busy_in_ov", {31'd0, busy}, 32'd0);
        seg_100  = 7'h7F;
        seg_10   = 7'h7E;
        seg_1    = 7'h5F;
        in_valid = 1'b1;
        sb.push_back('{bin: 10'd806, err: 1'b0, due: cyc + 13});
        @(negedge clk);
        in_valid = 1'b0;
        drain("b2b");

        // reset in the middle of CONV aborts without a pulse
        drive(7'h7B, 7'h30, 7'h6D, 10'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("abort_out_binary", {22'd0, out_binary}, 32'd0);
        chk("abort_out_err",    {31'd0, out_err}, 32'd0);
        chk("abort_busy",       {31'd0, busy}, 32'd0);
        repeat (15) @(negedge clk);

        drive(7'h30, 7'h30, 7'h30, 10'd111, 1'b0, 1'b1);
        drain("v111");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
